mux_tree_pipe: RTL and testbench

//  - N:1 data mux built as a radix-RADIX tree, PIPELINE register stages spread across tree levels.
//  - Valid/ready handshake on input and output; backpressure stalls the whole pipe.
//  - Sits wherever muxpipe is too slow or wide to close timing combinationally: arbiter output paths, wide readback buses.

---
 rtl/mux_tree_pipe_pkg.sv | 44 ++++
 rtl/mux_tree_level.sv | 25 ++
 rtl/mux_tree_pipe.sv | 157 +++++++++++++++
 tb/tb_mux_tree_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_tree_pipe_pkg.sv
// Shared helpers for the pipelined mux tree: tree depth, register placement and
// the select-digit container type.
package mux_tree_pipe_pkg;

  localparam int unsigned MaxLevels = 16;

  // Zero-extended select, one digit per tree level (LSB digit feeds level 0).
  typedef logic [2*MaxLevels-1:0] sel_digits_t;

  // Number of tree levels: ceil(log_radix(inputs)).
  function automatic int unsigned levels(input int unsigned inputs, input int unsigned radix);
    int unsigned n;
    int unsigned l;
    n = 1;
    l = 0;
    while (n < inputs) begin
      n = n * radix;
      l = l + 1;
    end
    return l;
  endfunction

  // Select bits consumed per level.
  function automatic int unsigned digit_width(input int unsigned radix);
    return (radix == 4) ? 2 : 1;
  endfunction

  // Tree level that register stage i follows.
  function automatic int stage_after_level(input int unsigned i, input int unsigned pipeline,
                                           input int unsigned levels);
    if (pipeline == 0) return -1;
    return int'(((i + 1) * levels) / pipeline) - 1;
  endfunction

  // True when some register stage sits right after the given level.
  function automatic bit has_stage(input int unsigned level, input int unsigned pipeline,
                                   input int unsigned levels);
    for (int unsigned i = 0; i < pipeline; i++) begin
      if (stage_after_level(i, pipeline, levels) == int'(level)) return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/mux_tree_level.sv
// One combinational level of the mux tree: NIN items reduced to NIN/RADIX items,
// every node steered by the same select digit.
module mux_tree_level
  import mux_tree_pipe_pkg::*;
#(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned NIN    = 4,
  parameter int unsigned RADIX  = 2
) (
  input  logic [NIN*DWIDTH-1:0]           i_data,
  input  logic [digit_width(RADIX)-1:0]   i_sel,
  output logic [(NIN/RADIX)*DWIDTH-1:0]   o_data
);

  localparam int unsigned NOUT = NIN / RADIX;

  // RADIX:1 mux per output node
  always_comb begin
    o_data = '0;
    for (int unsigned g = 0; g < NOUT; g++) begin
      o_data[g*DWIDTH +: DWIDTH] = i_data[(g*RADIX + 32'(i_sel))*DWIDTH +: DWIDTH];
    end
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// N:1 mux built as a radix-RADIX tree with PIPELINE register stages spread over
// the levels and a single global advance for valid/ready backpressure.
// Optional feature macro: MUX_TREE_PIPE_SEL_CHK_EN (sticky out-of-range select flag).
module mux_tree_pipe
  import mux_tree_pipe_pkg::*;
#(
  parameter int unsigned DWIDTH   = 16,
  parameter int unsigned INPUTS   = 4,
  parameter int unsigned RADIX    = 2,
  parameter int unsigned PIPELINE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DWIDTH*INPUTS-1:0]   data,
  input  logic [$clog2(INPUTS)-1:0]  sel,
  output logic                       q_valid,
  input  logic                       q_ready,
  output logic [DWIDTH-1:0]          q,
  output logic                       err
);

  localparam int unsigned LEVELS = levels(INPUTS, RADIX);
  localparam int unsigned DW     = digit_width(RADIX);
  localparam int unsigned NPAD   = RADIX ** LEVELS;
  localparam int unsigned SW     = $clog2(INPUTS);

  // Bit offset of the data vector entering level k (k == LEVELS is the final item).
  function automatic int unsigned doff(input int unsigned k);
    int unsigned s;
    s = 0;
    for (int unsigned j = 0; j < k; j++) s = s + RADIX ** (LEVELS - j);
    return s * DWIDTH;
  endfunction

  // Bit offset of the remaining select digits entering level k.
  function automatic int unsigned soff(input int unsigned k);
    int unsigned s;
    s = 0;
    for (int unsigned j = 0; j < k; j++) s = s + (LEVELS - j) * DW;
    return s;
  endfunction

  localparam int unsigned DTOT = doff(LEVELS) + DWIDTH;
  localparam int unsigned STOT = soff(LEVELS);

  if (INPUTS < 2 || !(RADIX == 2 || RADIX == 4) || PIPELINE > LEVELS
      || LEVELS > MaxLevels) begin : g_param_err
    $error("mux_tree_pipe: illegal INPUTS/RADIX/PIPELINE combination");
  end

  // Each level's input lives in its own slice so every bit has one driver and one reader.
  logic [DTOT-1:0]   w_data;
  logic [STOT-1:0]   w_sel;
  logic [LEVELS:0]   w_vld;
  logic              w_adv;

  // Whole pipe moves together; no bubble collapsing.
  assign w_adv    = ~q_valid | q_ready;
  assign in_ready = (PIPELINE == 0) ? q_ready : w_adv;

  assign w_data[0 +: INPUTS*DWIDTH] = data;
  if (NPAD > INPUTS) begin : g_data_pad
    assign w_data[INPUTS*DWIDTH +: (NPAD-INPUTS)*DWIDTH] = '0;
  end

  assign w_sel[0 +: SW] = sel;
  if (LEVELS*DW > SW) begin : g_sel_pad
    assign w_sel[SW +: LEVELS*DW-SW] = '0;
  end

  assign w_vld[0] = in_valid;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned NIN  = RADIX ** (LEVELS - k);
    localparam int unsigned NOUT = NIN / RADIX;
    localparam int unsigned DI   = doff(k);
    localparam int unsigned DO   = doff(k + 1);
    localparam int unsigned SI   = soff(k);
    localparam int unsigned SO   = soff(k + 1);
    localparam int unsigned SWO  = (LEVELS - k - 1) * DW;

    logic [NOUT*DWIDTH-1:0] w_mux;

    mux_tree_level #(
      .DWIDTH (DWIDTH),
      .NIN    (NIN),
      .RADIX  (RADIX)
    ) u_level (
      .i_data (w_data[DI +: NIN*DWIDTH]),
      .i_sel  (w_sel[SI +: DW]),
      .o_data (w_mux)
    );

    if (has_stage(k, PIPELINE, LEVELS)) begin : g_reg
      logic [NOUT*DWIDTH-1:0] r_data;
      logic                   r_vld;

      // Stage data and valid load on advance; data loads regardless of valid
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data <= '0;
          r_vld  <= 1'b0;
        end else if (w_adv) begin
          r_data <= w_mux;
          r_vld  <= w_vld[k];
        end
      end

      assign w_data[DO +: NOUT*DWIDTH] = r_data;
      assign w_vld[k+1]                = r_vld;

      if (k < LEVELS - 1) begin : g_sel
        logic [SWO-1:0] r_sel;

        // Unconsumed select digits travel alongside the partial result
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_sel <= '0;
          end else if (w_adv) begin
            r_sel <= w_sel[SI+DW +: SWO];
          end
        end

        assign w_sel[SO +: SWO] = r_sel;
      end
    end else begin : g_comb
      assign w_data[DO +: NOUT*DWIDTH] = w_mux;
      assign w_vld[k+1]                = w_vld[k];
      if (k < LEVELS - 1) begin : g_sel
        assign w_sel[SO +: SWO] = w_sel[SI+DW +: SWO];
      end
    end
  end

  assign q       = w_data[doff(LEVELS) +: DWIDTH];
  assign q_valid = w_vld[LEVELS];

`ifdef MUX_TREE_PIPE_SEL_CHK_EN
  logic r_err;

  // Sticky flag: an accepted beat addressed the zero padding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (in_valid && in_ready && (sel_digits_t'(sel) >= sel_digits_t'(INPUTS))) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe: four instances cover the combinational,
// streaming, backpressure, out-of-range select and mid-flight reset cases.
module tb_mux_tree_pipe;

`ifdef MUX_TREE_PIPE_SEL_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // u0: 4 inputs, radix 2, combinational, 4-bit data
  logic        c0_in_valid, c0_in_ready, c0_q_valid, c0_q_ready, c0_err;
  logic [15:0] c0_data;
  logic [1:0]  c0_sel;
  logic [3:0]  c0_q;
  mux_tree_pipe #(.DWIDTH(4), .INPUTS(4), .RADIX(2), .PIPELINE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(c0_in_valid), .in_ready(c0_in_ready),
    .data(c0_data), .sel(c0_sel), .q_valid(c0_q_valid), .q_ready(c0_q_ready),
    .q(c0_q), .err(c0_err)
  );

  // u1: 8 inputs, radix 2, 3 stages
  logic         c1_in_valid, c1_in_ready, c1_q_valid, c1_q_ready, c1_err;
  logic [127:0] c1_data;
  logic [2:0]   c1_sel;
  logic [15:0]  c1_q;
  mux_tree_pipe #(.DWIDTH(16), .INPUTS(8), .RADIX(2), .PIPELINE(3)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(c1_in_valid), .in_ready(c1_in_ready),
    .data(c1_data), .sel(c1_sel), .q_valid(c1_q_valid), .q_ready(c1_q_ready),
    .q(c1_q), .err(c1_err)
  );

  // u2: 16 inputs, radix 4, 2 stages
  logic         c2_in_valid, c2_in_ready, c2_q_valid, c2_q_ready, c2_err;
  logic [255:0] c2_data;
  logic [3:0]   c2_sel;
  logic [15:0]  c2_q;
  mux_tree_pipe #(.DWIDTH(16), .INPUTS(16), .RADIX(4), .PIPELINE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(c2_in_valid), .in_ready(c2_in_ready),
    .data(c2_data), .sel(c2_sel), .q_valid(c2_q_valid), .q_ready(c2_q_ready),
    .q(c2_q), .err(c2_err)
  );

  // u3: 5 inputs (padded to 8), radix 2, 2 stages
  logic        c3_in_valid, c3_in_ready, c3_q_valid, c3_q_ready, c3_err;
  logic [79:0] c3_data;
  logic [2:0]  c3_sel;
  logic [15:0] c3_q;
  mux_tree_pipe #(.DWIDTH(16), .INPUTS(5), .RADIX(2), .PIPELINE(2)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(c3_in_valid), .in_ready(c3_in_ready),
    .data(c3_data), .sel(c3_sel), .q_valid(c3_q_valid), .q_ready(c3_q_ready),
    .q(c3_q), .err(c3_err)
  );

  logic [15:0] sb1[$];
  logic [15:0] sb2[$];
  logic [15:0] sb3[$];
  int rx1 = 0;
  int rx2 = 0;

  // Scoreboards: push on accepted input, pop on completed output handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (c1_q_valid && c1_q_ready) begin
        rx1++;
        if (sb1.size() == 0) check("u1_unexpected_beat", 32'(c1_q_valid), 32'd0);
        else check("u1_q", 32'(c1_q), 32'(sb1.pop_front()));
      end
      if (c1_in_valid && c1_in_ready) sb1.push_back(16'h0100 + 16'(c1_sel));

      if (c2_q_valid && c2_q_ready) begin
        rx2++;
        if (sb2.size() == 0) check("u2_unexpected_beat", 32'(c2_q_valid), 32'd0);
        else check("u2_q", 32'(c2_q), 32'(sb2.pop_front()));
      end
      if (c2_in_valid && c2_in_ready) sb2.push_back(16'h2000 + 16'(c2_sel) * 16'h0011);

      if (c3_q_valid && c3_q_ready) begin
        if (sb3.size() == 0) check("u3_unexpected_beat", 32'(c3_q_valid), 32'd0);
        else check("u3_q", 32'(c3_q), 32'(sb3.pop_front()));
      end
      if (c3_in_valid && c3_in_ready)
        sb3.push_back((c3_sel < 3'd5) ? 16'h3000 + 16'(c3_sel) : 16'h0000);
    end
  end

  initial begin
    int          idx;
    logic        rdy;
    logic [15:0] held;

    c0_in_valid = 1'b0; c0_q_ready = 1'b0; c0_data = 16'hDCBA; c0_sel = '0;
    c1_in_valid = 1'b0; c1_q_ready = 1'b1; c1_sel = '0;
    c2_in_valid = 1'b0; c2_q_ready = 1'b1; c2_sel = '0;
    c3_in_valid = 1'b0; c3_q_ready = 1'b1; c3_sel = '0;
    for (int i = 0; i < 8; i++) c1_data[i*16 +: 16] = 16'h0100 + 16'(i);
    for (int i = 0; i < 16; i++) c2_data[i*16 +: 16] = 16'h2000 + 16'(i) * 16'h0011;
    for (int i = 0; i < 5; i++) c3_data[i*16 +: 16] = 16'h3000 + 16'(i);

    repeat (3) tick();
    check("rst_u1_q_valid", 32'(c1_q_valid), 32'd0);
    check("rst_u1_q", 32'(c1_q), 32'd0);
    check("rst_u2_q_valid", 32'(c2_q_valid), 32'd0);
    check("rst_u3_q", 32'(c3_q), 32'd0);
    check("rst_u3_err", 32'(c3_err), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_u1_in_ready", 32'(c1_in_ready), 32'd1);

    // Combinational instance
    c0_in_valid = 1'b1; c0_q_ready = 1'b1; c0_sel = 2'd2;
    #1;
    check("u0_q_sel2", 32'(c0_q), 32'hC);
    check("u0_q_valid", 32'(c0_q_valid), 32'd1);
    check("u0_in_ready", 32'(c0_in_ready), 32'd1);
    c0_sel = 2'd0;
    #1 check("u0_q_sel0", 32'(c0_q), 32'hA);
    c0_sel = 2'd3; c0_in_valid = 1'b0; c0_q_ready = 1'b0;
    #1;
    check("u0_q_sel3", 32'(c0_q), 32'hD);
    check("u0_q_valid_low", 32'(c0_q_valid), 32'd0);
    check("u0_in_ready_low", 32'(c0_in_ready), 32'd0);
    check("u0_err", 32'(c0_err), 32'd0);
    tick();

    // u1 stream sel 0..7: q_valid high in cycles 3..10 exactly
    for (int c = 0; c < 12; c++) begin
      c1_in_valid = (c < 8);
      c1_sel = 3'(c);
      @(negedge clk);
      check($sformatf("u1_q_valid_c%0d", c), 32'(c1_q_valid), 32'((c >= 3) && (c <= 10)));
      tick();
    end
    check("u1_rx_count", 32'(rx1), 32'd8);
    check("u1_sb_empty", 32'(sb1.size()), 32'd0);

    // u2 stream with q_ready low for 5 cycles mid-stream
    idx = 0;
    held = '0;
    for (int c = 0; c < 30; c++) begin
      c2_q_ready = !((c >= 4) && (c < 9));
      c2_in_valid = (idx < 12);
      c2_sel = 4'((idx * 5) % 16);
      @(negedge clk);
      rdy = c2_in_ready;
      if (c == 4) begin
        held = c2_q;
        check("u2_stall_q_valid", 32'(c2_q_valid), 32'd1);
      end
      if ((c >= 4) && (c < 9)) begin
        check($sformatf("u2_stall_in_ready_c%0d", c), 32'(rdy), 32'd0);
        check($sformatf("u2_stall_q_c%0d", c), 32'(c2_q), 32'(held));
      end
      @(posedge clk);
      if (c2_in_valid && rdy) idx++;
      #1;
    end
    c2_in_valid = 1'b0;
    check("u2_rx_count", 32'(rx2), 32'd12);
    check("u2_sb_empty", 32'(sb2.size()), 32'd0);

    // u3 out-of-range select
    c3_in_valid = 1'b1; c3_sel = 3'd1;
    @(negedge clk) check("u3_err_before", 32'(c3_err), 32'd0);
    tick();
    c3_sel = 3'd6;
    @(negedge clk) check("u3_err_at_accept", 32'(c3_err), 32'd0);
    tick();
    c3_sel = 3'd4;
    @(negedge clk) check("u3_err_next", 32'(c3_err), 32'(EXP_ERR));
    tick();
    c3_in_valid = 1'b0;
    @(negedge clk);
    check("u3_oob_q_valid", 32'(c3_q_valid), 32'd1);
    check("u3_oob_q", 32'(c3_q), 32'd0);
    repeat (5) tick();
    check("u3_err_sticky", 32'(c3_err), 32'(EXP_ERR));
    check("u3_sb_empty", 32'(sb3.size()), 32'd0);

    // u1 mid-flight reset with 3 beats in the pipe
    rx1 = 0;
    for (int c = 0; c < 3; c++) begin
      c1_in_valid = 1'b1;
      c1_sel = 3'(c + 1);
      tick();
    end
    c1_in_valid = 1'b0;
    check("u1_pre_rst_q_valid", 32'(c1_q_valid), 32'd1);
    rst_n = 1'b0;
    sb1.delete();
    #1;
    check("u1_rst_q_valid", 32'(c1_q_valid), 32'd0);
    check("u1_rst_q", 32'(c1_q), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("u1_post_rst_q_valid_c%0d", c), 32'(c1_q_valid), 32'd0);
      tick();
    end
    check("u1_post_rst_rx", 32'(rx1), 32'd0);
    check("u3_err_cleared", 32'(c3_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
